seg_frame_feeder: RTL and testbench



---
 rtl/seg_frame_feeder.sv | 165 ++++++++++++++++
 tb/tb_seg_frame_feeder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_feeder.sv
// seg_frame_feeder: encodes hex digits into active-low 7-segment bytes and
// hands paced frames (data + start) to the downstream serial shifter.
module seg_frame_feeder #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter int unsigned START_HIGH     = 2,
  parameter int unsigned SHIFT_GAP      = 8 * DIGITS + 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     les,
  input  logic                  update,
  output logic [8*DIGITS-1:0]   data,
  output logic                  start,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned FW = 8 * DIGITS;
  localparam int unsigned GW = $clog2(SHIFT_GAP + 1);
  localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [FW-1:0]   data_d;
  logic            start_d;
  logic            busy_d;
  logic            done_d;
  logic [GW-1:0]   gap, gap_d;
  logic            pending, pending_d;
  logic            refresh_hit;
  logic            trigger;
  logic [FW-1:0]   enc;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Free-running refresh timer; absent entirely when REFRESH_CYCLES is 0
  if (REFRESH_CYCLES != 0) begin : g_refresh
    logic [RW-1:0] refresh_cnt;

    assign refresh_hit = (refresh_cnt == RW'(REFRESH_CYCLES - 1));

    // Count up and wrap on expiry
    always_ff @(posedge clk) begin
      if (rst) begin
        refresh_cnt <= '0;
      end else if (refresh_hit) begin
        refresh_cnt <= '0;
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
    end
  end else begin : g_no_refresh
    assign refresh_hit = 1'b0;
  end

  // Update strobe and refresh expiry merge into a single request
  assign trigger = update | refresh_hit;

  // Encode all digits; blanked digits are forced fully dark
  always_comb begin
    enc = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      enc[8*i +: 8] = les[i] ? 8'hFF : ~{points[i], seg7(hexs[4*i +: 4])};
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d   = state;
    data_d    = data;
    start_d   = start;
    busy_d    = busy;
    done_d    = 1'b0;
    gap_d     = gap;
    pending_d = pending;
    case (state)
      S_IDLE: begin
        if (trigger || pending) begin
          data_d    = enc;
          pending_d = 1'b0;
          busy_d    = 1'b1;
          start_d   = 1'b1;
          gap_d     = GW'(1);
          state_d   = S_ARM;
        end
      end
      S_ARM: begin
        if (trigger) pending_d = 1'b1;
        gap_d = gap + GW'(1);
        if (gap == GW'(START_HIGH)) begin
          start_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (trigger) pending_d = 1'b1;
        gap_d = gap + GW'(1);
        if (gap == GW'(SHIFT_GAP)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          gap_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
        busy_d  = 1'b0;
        gap_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      data       <= '1;
      start      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      gap        <= '0;
      pending    <= 1'b0;
    end else begin
      state      <= state_d;
      data       <= data_d;
      start      <= start_d;
      busy       <= busy_d;
      frame_done <= done_d;
      gap        <= gap_d;
      pending    <= pending_d;
    end
  end

endmodule

// File: tb/tb_seg_frame_feeder.sv
// Directed bench for seg_frame_feeder: one instance with refresh disabled,
// one with a 200-cycle refresh period.
module tb_seg_frame_feeder;

  logic        clk = 1'b0;
  logic        rst, rst_b;
  logic [31:0] hexs;
  logic [7:0]  points, les;
  logic        update, upd_b;
  logic [63:0] data_a, data_b;
  logic        start_a, start_b, busy_a, busy_b, done_a, done_b;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rises_a = 0, last_rise_a = 0, prev_rise_a = 0;
  int rises_b = 0, last_rise_b = 0, prev_rise_b = 0;
  logic start_qa = 1'b0, start_qb = 1'b0;

  always #5 clk = ~clk;

  seg_frame_feeder #(.DIGITS(8), .REFRESH_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst), .hexs(hexs), .points(points), .les(les),
    .update(update), .data(data_a), .start(start_a), .busy(busy_a),
    .frame_done(done_a)
  );

  seg_frame_feeder #(.DIGITS(8), .REFRESH_CYCLES(200)) u_ref (
    .clk(clk), .rst(rst_b), .hexs(hexs), .points(points), .les(les),
    .update(upd_b), .data(data_b), .start(start_b), .busy(busy_b),
    .frame_done(done_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record start rising edges and their cycle stamps
  always @(negedge clk) begin
    start_qa <= start_a;
    start_qb <= start_b;
    if (start_a && !start_qa) begin
      rises_a     <= rises_a + 1;
      prev_rise_a <= last_rise_a;
      last_rise_a <= cyc;
    end
    if (start_b && !start_qb) begin
      rises_b     <= rises_b + 1;
      prev_rise_b <= last_rise_b;
      last_rise_b <= cyc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_a !== 1'b1 && k < 200) begin
      tick;
      k++;
    end
    check(tag, 64'(done_a), 64'd1);
  endtask

  task automatic wait_rises(input bit sel, input int target, input int bound, input string tag);
    int k = 0;
    while (((sel ? rises_b : rises_a) < target) && k < bound) begin
      tick;
      k++;
    end
    check(tag, 64'(sel ? rises_b : rises_a), 64'(target));
  endtask

  initial begin
    int r0, r1, rel;
    rst = 1'b1; rst_b = 1'b1; update = 1'b0; upd_b = 1'b0;
    hexs = '0; points = '0; les = '0;
    tick; tick;
    rst = 1'b0;
    tick;
    check("reset_data", data_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check("reset_start", 64'(start_a), 64'd0);
    check("reset_busy", 64'(busy_a), 64'd0);
    check("reset_done", 64'(done_a), 64'd0);
    repeat (50) tick;
    check("idle_data", data_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check("idle_busy", 64'(busy_a), 64'd0);
    check("idle_no_frame", 64'(rises_a), 64'd0);

    // Digits 0..7, single update
    hexs = 32'h7654_3210; update = 1'b1;
    tick;
    update = 1'b0;
    check("enc_digits", data_a, 64'hF882_9299_B0A4_F9C0);
    check("start_c1", 64'(start_a), 64'd1);
    check("busy_c1", 64'(busy_a), 64'd1);
    tick;
    check("start_c2", 64'(start_a), 64'd1);
    tick;
    check("start_c3_low", 64'(start_a), 64'd0);
    check("busy_wait", 64'(busy_a), 64'd1);
    wait_done("frame_done_seen");
    check("gap_68", 64'(cyc - last_rise_a), 64'd68);
    check("busy_cleared", 64'(busy_a), 64'd0);
    tick;
    check("done_one_cycle", 64'(done_a), 64'd0);

    // Decimal point on digit 0, digit 7 blanked
    hexs = '0; points = 8'h01; les = 8'h80; update = 1'b1;
    tick;
    update = 1'b0;
    check("enc_dp_blank", data_a, 64'hFFC0_C0C0_C0C0_C040);
    wait_done("frame2_done");

    // Coalesced triggers during WAIT; inputs sampled at service time
    points = '0; les = '0; hexs = '0; update = 1'b1;
    tick;
    update = 1'b0;
    check("enc_zeros", data_a, 64'hC0C0_C0C0_C0C0_C0C0);
    repeat (12) tick;
    r0 = rises_a;
    update = 1'b1; tick; update = 1'b0; tick;
    update = 1'b1; tick; update = 1'b0; tick;
    update = 1'b1; tick; update = 1'b0;
    hexs = 32'hFFFF_FFFF;
    wait_done("frame3_done");
    check("data_held_in_wait", data_a, 64'hC0C0_C0C0_C0C0_C0C0);
    wait_rises(1'b0, r0 + 1, 20, "pending_frame_rise");
    check("pending_interval", 64'(last_rise_a - prev_rise_a), 64'd69);
    check("pending_data", data_a, 64'h8E8E_8E8E_8E8E_8E8E);
    wait_done("frame4_done");
    repeat (150) tick;
    check("one_extra_frame", 64'(rises_a), 64'(r0 + 1));

    // Reset mid-WAIT with a pending request
    hexs = '0; update = 1'b1;
    tick;
    update = 1'b0;
    repeat (12) tick;
    update = 1'b1; tick; update = 1'b0; tick;
    rst = 1'b1; tick; rst = 1'b0;
    check("rst_start", 64'(start_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_data", data_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_done", 64'(done_a), 64'd0);
    r1 = rises_a;
    repeat (150) tick;
    check("rst_pending_lost", 64'(rises_a), 64'(r1));
    update = 1'b1;
    tick;
    update = 1'b0;
    check("after_rst_start", 64'(start_a), 64'd1);
    check("after_rst_data", data_a, 64'hC0C0_C0C0_C0C0_C0C0);

    // Periodic refresh instance
    hexs = 32'h7654_3210; points = '0; les = '0;
    tick;
    rel = cyc;
    rst_b = 1'b0;
    wait_rises(1'b1, 1, 300, "refresh_first");
    check("refresh_first_time", 64'(last_rise_b - rel), 64'd200);
    check("refresh_data1", data_b, 64'hF882_9299_B0A4_F9C0);
    hexs = 32'h89AB_CDEF;
    wait_rises(1'b1, 2, 250, "refresh_second");
    check("refresh_period", 64'(last_rise_b - prev_rise_b), 64'd200);
    check("refresh_data2", data_b, 64'h8090_8883_C6A1_868E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
